// File: rtl/slave_rx_assembler_if.sv
// ---------------------------------------------------------------------------
// slave_rx_assembler_if
//
// Purpose: bundles the field-level receive bus (slave RX FSM -> assembler)
// and the assembled-transaction bus (assembler -> consumer) used by
// slave_rx_assembler.
//
// Handshake semantics:
//   Receive side: each i_*_valid presents one field for one cycle. A field
//   is consumed on a rising edge where its valid is high and o_rx_ready is
//   high. Fields presented while o_rx_ready is low are ignored, not held
//   off, so the producer must watch o_rx_ready itself.
//   Transaction side: o_txn_valid stays high with every o_txn_* field
//   stable until a rising edge where i_txn_ready is also high. That edge
//   transfers the transaction. o_txn_valid never depends on i_txn_ready.
//
// Signals:
//   i_cmd/i_cmd_valid             3-bit command (000 rd req, 001 wr req, 010 rd resp)
//   i_addr/i_addr_valid           WORD_SIZE-bit address
//   i_length/i_length_valid       3-bit size code (000=4B ... 101=128B)
//   i_feature1/2, *_valid         6-bit extended-mode feature fields
//   i_data/i_data_valid           one WORD_SIZE-bit data word per valid cycle
//   o_rx_ready                    assembler can take fields
//   o_txn_valid/i_txn_ready       transaction handshake
//   o_txn_cmd/length/addr/feature1/feature2/data/words/err  captured transaction
//
// Modports: master = field producer / transaction consumer side,
//           slave  = the assembler.
// ---------------------------------------------------------------------------
interface slave_rx_assembler_if #(
    parameter int WORD_SIZE = 32,
    parameter int MAX_WORDS = 32
);
    logic [2:0]                     i_cmd;
    logic                           i_cmd_valid;
    logic [WORD_SIZE-1:0]           i_addr;
    logic                           i_addr_valid;
    logic [2:0]                     i_length;
    logic                           i_length_valid;
    logic [5:0]                     i_feature1;
    logic                           i_feature1_valid;
    logic [5:0]                     i_feature2;
    logic                           i_feature2_valid;
    logic [WORD_SIZE-1:0]           i_data;
    logic                           i_data_valid;
    logic                           o_rx_ready;

    logic                           o_txn_valid;
    logic                           i_txn_ready;
    logic [2:0]                     o_txn_cmd;
    logic [2:0]                     o_txn_length;
    logic [WORD_SIZE-1:0]           o_txn_addr;
    logic [5:0]                     o_txn_feature1;
    logic [5:0]                     o_txn_feature2;
    logic [MAX_WORDS*WORD_SIZE-1:0] o_txn_data;
    logic [5:0]                     o_txn_words;
    logic                           o_txn_err;

    modport master (
        output i_cmd, i_cmd_valid, i_addr, i_addr_valid, i_length, i_length_valid,
        output i_feature1, i_feature1_valid, i_feature2, i_feature2_valid,
        output i_data, i_data_valid, i_txn_ready,
        input  o_rx_ready, o_txn_valid, o_txn_cmd, o_txn_length, o_txn_addr,
        input  o_txn_feature1, o_txn_feature2, o_txn_data, o_txn_words, o_txn_err
    );

    modport slave (
        input  i_cmd, i_cmd_valid, i_addr, i_addr_valid, i_length, i_length_valid,
        input  i_feature1, i_feature1_valid, i_feature2, i_feature2_valid,
        input  i_data, i_data_valid, i_txn_ready,
        output o_rx_ready, o_txn_valid, o_txn_cmd, o_txn_length, o_txn_addr,
        output o_txn_feature1, o_txn_feature2, o_txn_data, o_txn_words, o_txn_err
    );
endinterface

// File: rtl/slave_rx_assembler.sv
// ---------------------------------------------------------------------------
// slave_rx_assembler
//
// Purpose: collects the individually-validated fields produced by the slave
// RX FSM (command, address, length, optional features, data words) into one
// transaction. The transaction is held on the output until the consumer
// accepts it. Protocol anomalies (repeated fields, excess data, bad length,
// unknown command, a new command mid-transaction) still complete the
// transaction, with o_txn_err set.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        slave_rx_assembler_if.slave (field inputs, o_rx_ready,
//              transaction outputs, i_txn_ready)
//   dbg_state  current FSM state (0 IDLE, 1 COLLECT, 2 HOLD)
//   o_stat_txn_cnt / o_stat_err_cnt  (only with SLAVE_RX_ASSEMBLER_STATS_EN)
//              16-bit wrapping counts of accepted transactions and of
//              accepted transactions carrying err
//
// Configuration macro: SLAVE_RX_ASSEMBLER_STATS_EN enables the statistics
// counters and ports. When it is undefined they are absent.
// ---------------------------------------------------------------------------
module slave_rx_assembler #(
    parameter int WORD_SIZE = 32,
    parameter int MAX_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    slave_rx_assembler_if.slave  bus,
    output logic [1:0]           dbg_state
`ifdef SLAVE_RX_ASSEMBLER_STATS_EN
    ,
    output logic [15:0]          o_stat_txn_cnt,
    output logic [15:0]          o_stat_err_cnt
`endif
);

    localparam int          IDXW   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [5:0]  MAX_W6 = 6'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t               state_q, state_n;

    logic [2:0]           cmd_q, cmd_n;
    logic [2:0]           len_q, len_n;
    logic [WORD_SIZE-1:0] addr_q, addr_n;
    logic [5:0]           f1_q, f1_n;
    logic [5:0]           f2_q, f2_n;
    logic [5:0]           words_q, words_n;
    logic                 err_q, err_n;
    logic                 have_len_q, have_len_n;
    logic                 have_addr_q, have_addr_n;
    logic                 have_f1_q, have_f1_n;
    logic                 have_f2_q, have_f2_n;

    logic [WORD_SIZE-1:0] data_q [MAX_WORDS];
    logic                 data_we;
    logic [IDXW-1:0]      data_idx;

    logic                 capture;
    logic                 complete;
    logic [5:0]           exp_words;

    // Next-state and capture logic. Every capture register gets a "next"
    // value that already includes this cycle's fields, so completion is
    // judged on the post-edge contents and HOLD is entered on the same edge
    // that consumes the last field.
    always_comb begin
        state_n     = state_q;
        cmd_n       = cmd_q;
        len_n       = len_q;
        addr_n      = addr_q;
        f1_n        = f1_q;
        f2_n        = f2_q;
        words_n     = words_q;
        err_n       = err_q;
        have_len_n  = have_len_q;
        have_addr_n = have_addr_q;
        have_f1_n   = have_f1_q;
        have_f2_n   = have_f2_q;
        data_we     = 1'b0;
        data_idx    = '0;
        capture     = 1'b0;
        complete    = 1'b0;
        exp_words   = '0;

        case (state_q)
            ST_IDLE: begin
                // Stray fields without a command are dropped.
                if (bus.i_cmd_valid) begin
                    capture     = 1'b1;
                    cmd_n       = bus.i_cmd;
                    len_n       = '0;
                    addr_n      = '0;
                    f1_n        = '0;
                    f2_n        = '0;
                    words_n     = '0;
                    err_n       = (bus.i_cmd > 3'b010);
                    have_len_n  = 1'b0;
                    have_addr_n = 1'b0;
                    have_f1_n   = 1'b0;
                    have_f2_n   = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (bus.i_cmd_valid) begin
                    // A new command cuts the current transaction short. The
                    // new command and its same-cycle fields are consumed and
                    // lost.
                    err_n   = 1'b1;
                    state_n = ST_HOLD;
                end else begin
                    capture = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.i_txn_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (capture) begin
            if (bus.i_addr_valid) begin
                if (have_addr_n) err_n = 1'b1;
                addr_n      = bus.i_addr;
                have_addr_n = 1'b1;
            end
            if (bus.i_length_valid) begin
                if (have_len_n || bus.i_length > 3'b101) err_n = 1'b1;
                len_n      = bus.i_length;
                have_len_n = 1'b1;
            end
            if (bus.i_feature1_valid) begin
                if (have_f1_n) err_n = 1'b1;
                f1_n      = bus.i_feature1;
                have_f1_n = 1'b1;
            end
            if (bus.i_feature2_valid) begin
                if (have_f2_n) err_n = 1'b1;
                f2_n      = bus.i_feature2;
                have_f2_n = 1'b1;
            end

            // Only write requests and read responses carry data; a reserved
            // length code carries none.
            if ((cmd_n == 3'b001 || cmd_n == 3'b010) && len_n <= 3'b101) begin
                exp_words = 6'd1 << len_n;
            end

            // Until the length is known, words are stored up to capacity.
            if (bus.i_data_valid) begin
                if (words_n < MAX_W6 && (!have_len_n || words_n < exp_words)) begin
                    data_we  = 1'b1;
                    data_idx = words_n[IDXW-1:0];
                    words_n  = words_n + 6'd1;
                end else begin
                    err_n = 1'b1;
                end
            end

            // Words that turn out to exceed a late-arriving length are
            // dropped by trimming the count back to the expected size.
            if (have_len_n && words_n > exp_words) begin
                words_n = exp_words;
                err_n   = 1'b1;
            end

            // Commands 000/001 need an address; 010 and unknown ones do not.
            complete = have_len_n && (words_n == exp_words) &&
                       (have_addr_n || cmd_n[2:1] != 2'b00);
            state_n  = complete ? ST_HOLD : ST_COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            f1_q        <= '0;
            f2_q        <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            have_len_q  <= 1'b0;
            have_addr_q <= 1'b0;
            have_f1_q   <= 1'b0;
            have_f2_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            cmd_q       <= cmd_n;
            len_q       <= len_n;
            addr_q      <= addr_n;
            f1_q        <= f1_n;
            f2_q        <= f2_n;
            words_q     <= words_n;
            err_q       <= err_n;
            have_len_q  <= have_len_n;
            have_addr_q <= have_addr_n;
            have_f1_q   <= have_f1_n;
            have_f2_q   <= have_f2_n;
        end
    end

    // The data store is not wiped per transaction. The output mask below
    // hides any word at or above the current count, which is equivalent
    // for every observer and avoids a wide clear path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_WORDS; k++) begin
                data_q[k] <= '0;
            end
        end else if (data_we) begin
            data_q[data_idx] <= bus.i_data;
        end
    end

    always_comb begin
        bus.o_txn_data = '0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (6'(k) < words_q) begin
                bus.o_txn_data[k*WORD_SIZE +: WORD_SIZE] = data_q[k];
            end
        end
    end

    assign bus.o_rx_ready     = (state_q != ST_HOLD);
    assign bus.o_txn_valid    = (state_q == ST_HOLD);
    assign bus.o_txn_cmd      = cmd_q;
    assign bus.o_txn_length   = len_q;
    assign bus.o_txn_addr     = addr_q;
    assign bus.o_txn_feature1 = f1_q;
    assign bus.o_txn_feature2 = f2_q;
    assign bus.o_txn_words    = words_q;
    assign bus.o_txn_err      = err_q;
    assign dbg_state          = state_q;

`ifdef SLAVE_RX_ASSEMBLER_STATS_EN
    logic [15:0] stat_txn_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_txn_q <= '0;
            stat_err_q <= '0;
        end else if (state_q == ST_HOLD && bus.i_txn_ready) begin
            stat_txn_q <= stat_txn_q + 16'd1;
            if (err_q) stat_err_q <= stat_err_q + 16'd1;
        end
    end

    assign o_stat_txn_cnt = stat_txn_q;
    assign o_stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_slave_rx_assembler.sv
// ---------------------------------------------------------------------------
// tb_slave_rx_assembler
//
// Self-checking bench for slave_rx_assembler. Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle after the
// rising edge that updated them. Expected transactions come from a small
// reference model expressed in bytes and word counts.
// ---------------------------------------------------------------------------
module tb_slave_rx_assembler;

    localparam int WS   = 32;
    localparam int MW   = 32;
    localparam int SUMW = 3 + 3 + WS + 6 + 6 + 6 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected transaction summary {cmd, len, addr, f1, f2, words, err}
    logic [SUMW-1:0] exp_q[$];
    logic [WS-1:0]   exp_data_q[$];

    slave_rx_assembler_if #(.WORD_SIZE(WS), .MAX_WORDS(MW)) bus ();

`ifdef SLAVE_RX_ASSEMBLER_STATS_EN
    logic [15:0] stat_txn;
    logic [15:0] stat_err;
`endif

    slave_rx_assembler #(.WORD_SIZE(WS), .MAX_WORDS(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef SLAVE_RX_ASSEMBLER_STATS_EN
        ,
        .o_stat_txn_cnt (stat_txn),
        .o_stat_err_cnt (stat_err)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish, got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_fields();
        bus.i_cmd_valid      = 1'b0;
        bus.i_addr_valid     = 1'b0;
        bus.i_length_valid   = 1'b0;
        bus.i_feature1_valid = 1'b0;
        bus.i_feature2_valid = 1'b0;
        bus.i_data_valid     = 1'b0;
        bus.i_txn_ready      = 1'b0;
    endtask

    // Let one rising edge consume whatever is being driven, then idle inputs.
    task automatic tick();
        @(negedge clk);
        clear_fields();
    endtask

    task automatic drv_cmd(input logic [2:0] c);
        bus.i_cmd = c; bus.i_cmd_valid = 1'b1;
    endtask
    task automatic drv_len(input logic [2:0] l);
        bus.i_length = l; bus.i_length_valid = 1'b1;
    endtask
    task automatic drv_addr(input logic [WS-1:0] a);
        bus.i_addr = a; bus.i_addr_valid = 1'b1;
    endtask
    task automatic drv_f1(input logic [5:0] f);
        bus.i_feature1 = f; bus.i_feature1_valid = 1'b1;
    endtask
    task automatic drv_f2(input logic [5:0] f);
        bus.i_feature2 = f; bus.i_feature2_valid = 1'b1;
    endtask
    task automatic drv_data(input logic [WS-1:0] d);
        bus.i_data = d; bus.i_data_valid = 1'b1;
    endtask

    task automatic accept();
        bus.i_txn_ready = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        clear_fields();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid_quiet();
        for (int n = 0; n < 60 && bus.o_txn_valid !== 1'b1; n++) tick();
    endtask

    // ---------------- reference model ----------------
    // Payload size is 4 << code bytes for data-carrying commands.
    function automatic logic [5:0] model_words(input logic [2:0] c, input logic [2:0] l);
        int bytes;
        if (!(c == 3'd1 || c == 3'd2) || l > 3'd5) return 6'd0;
        bytes = 4 << l;
        return 6'(bytes / 4);
    endfunction

    function automatic logic model_err(input logic [2:0] c, input logic [2:0] l, input logic extra);
        return (c > 3'd2) || (l > 3'd5) || extra;
    endfunction

    task automatic model_push(input logic [2:0] c, input logic [2:0] l, input logic [WS-1:0] a,
                              input logic [5:0] f1, input logic [5:0] f2,
                              input logic [5:0] w, input logic e);
        exp_q.push_back({c, l, a, f1, f2, w, e});
    endtask

    function automatic logic [SUMW-1:0] obs();
        return {bus.o_txn_cmd, bus.o_txn_length, bus.o_txn_addr, bus.o_txn_feature1,
                bus.o_txn_feature2, bus.o_txn_words, bus.o_txn_err};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL reset_fields got %h exp 0", obs());
        end
        checks++;
        if (bus.o_txn_data !== '0) begin
            errors++; $display("FAIL reset_data got nonzero exp 0");
        end
        checks++;
        if (bus.o_txn_valid !== 1'b0 || bus.o_rx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_handshake got valid=%b ready=%b exp valid=0 ready=1",
                               bus.o_txn_valid, bus.o_rx_ready);
        end
    endtask

    task automatic test_basic();
        logic [SUMW-1:0] exp_s;
        drv_cmd(3'd1); drv_len(3'd1); drv_addr(32'hFFDD0000); tick();
        drv_data(32'h000000AA); tick();
        drv_data(32'h000000BB); tick();
        model_push(3'd1, 3'd1, 32'hFFDD0000, 6'd0, 6'd0, model_words(3'd1, 3'd1), model_err(3'd1, 3'd1, 1'b0));
        checks++;
        if (bus.o_txn_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency got valid=%b exp 1", bus.o_txn_valid);
        end
        exp_s = exp_q.pop_front();
        checks++;
        if (obs() !== exp_s) begin
            errors++; $display("FAIL basic_summary got %h exp %h", obs(), exp_s);
        end
        checks++;
        if (bus.o_txn_data[63:0] !== 64'h000000BB_000000AA) begin
            errors++; $display("FAIL basic_data got %h exp 000000bb000000aa", bus.o_txn_data[63:0]);
        end
        accept();
        checks++;
        if (bus.o_txn_valid !== 1'b0 || bus.o_rx_ready !== 1'b1) begin
            errors++; $display("FAIL basic_release got valid=%b ready=%b exp 0/1",
                               bus.o_txn_valid, bus.o_rx_ready);
        end
    endtask

    task automatic test_hold_stall();
        logic [SUMW-1:0] exp_s;
        drv_cmd(3'd0); drv_len(3'd2); drv_addr(32'h00000AAA); drv_f1(6'h02); drv_f2(6'h07); tick();
        model_push(3'd0, 3'd2, 32'h00000AAA, 6'h02, 6'h07, model_words(3'd0, 3'd2), model_err(3'd0, 3'd2, 1'b0));
        exp_s = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.o_txn_valid !== 1'b1 || bus.o_rx_ready !== 1'b0) begin
                errors++; $display("FAIL stall_handshake cyc %0d got valid=%b ready=%b exp 1/0",
                                   i, bus.o_txn_valid, bus.o_rx_ready);
            end
            checks++;
            if (obs() !== exp_s) begin
                errors++; $display("FAIL stall_stable cyc %0d got %h exp %h", i, obs(), exp_s);
            end
            // Fields offered while not ready must be ignored.
            drv_cmd(3'd1); drv_addr($urandom); drv_data($urandom); drv_len(3'd4);
            tick();
        end
        // Handshake cycle with a competing command: no same-cycle bypass.
        drv_cmd(3'd1); drv_len(3'd3);
        accept();
        checks++;
        if (bus.o_txn_valid !== 1'b0 || bus.o_rx_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got valid=%b ready=%b exp 0/1",
                               bus.o_txn_valid, bus.o_rx_ready);
        end
        drv_cmd(3'd0); drv_len(3'd0); drv_addr(32'hAABB0000); tick();
        model_push(3'd0, 3'd0, 32'hAABB0000, 6'd0, 6'd0, 6'd0, 1'b0);
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL no_bypass got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        accept();
    endtask

    task automatic test_excess();
        logic [SUMW-1:0] exp_s;
        logic [WS-1:0]   exp_w;
        drv_cmd(3'd2); tick();
        drv_data(32'h1234); tick();
        drv_data(32'h5678); tick();
        drv_data(32'h2444); tick();
        drv_len(3'd1); tick();
        // Two words fit the size; the third is surplus.
        model_push(3'd2, 3'd1, '0, 6'd0, 6'd0, model_words(3'd2, 3'd1), 1'b1);
        exp_data_q.push_back(32'h1234);
        exp_data_q.push_back(32'h5678);
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL excess_summary got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        for (int k = 0; k < 2; k++) begin
            exp_w = exp_data_q.pop_front();
            checks++;
            if (bus.o_txn_data[k*WS +: WS] !== exp_w) begin
                errors++; $display("FAIL excess_data[%0d] got %h exp %h", k, bus.o_txn_data[k*WS +: WS], exp_w);
            end
        end
        accept();
    endtask

    task automatic test_overflow();
        logic [SUMW-1:0] exp_s;
        logic [WS-1:0]   w;
        drv_cmd(3'd1); drv_addr(32'h0BAD0000); tick();
        for (int k = 0; k < MW + 1; k++) begin
            w = $urandom;
            if (k < MW) exp_data_q.push_back(w);
            drv_data(w); tick();
        end
        drv_len(3'd5); tick();
        model_push(3'd1, 3'd5, 32'h0BAD0000, 6'd0, 6'd0, model_words(3'd1, 3'd5), 1'b1);
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL overflow_summary got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        for (int k = 0; k < MW; k++) begin
            w = exp_data_q.pop_front();
            checks++;
            if (bus.o_txn_data[k*WS +: WS] !== w) begin
                errors++; $display("FAIL overflow_data[%0d] got %h exp %h", k, bus.o_txn_data[k*WS +: WS], w);
            end
        end
        accept();
    endtask

    task automatic test_bad_codes();
        logic [SUMW-1:0] exp_s;
        drv_cmd(3'd1); drv_len(3'd6); drv_addr(32'h00C0FFEE); tick();
        model_push(3'd1, 3'd6, 32'h00C0FFEE, 6'd0, 6'd0, model_words(3'd1, 3'd6), model_err(3'd1, 3'd6, 1'b0));
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL bad_length got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        accept();
        drv_cmd(3'd5); drv_len(3'd2); tick();
        model_push(3'd5, 3'd2, '0, 6'd0, 6'd0, model_words(3'd5, 3'd2), model_err(3'd5, 3'd2, 1'b0));
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL unknown_cmd got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        accept();
    endtask

    task automatic test_cmd_abort();
        logic [SUMW-1:0] exp_s;
        drv_cmd(3'd1); drv_len(3'd2); drv_addr(32'h12345678); tick();
        drv_data(32'hD0); tick();
        drv_data(32'hD1); tick();
        drv_cmd(3'd0); drv_len(3'd0); drv_addr(32'h99999999); tick();
        model_push(3'd1, 3'd2, 32'h12345678, 6'd0, 6'd0, 6'd2, 1'b1);
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL abort_summary got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        checks++;
        if (bus.o_txn_data[2*WS-1:0] !== {32'hD1, 32'hD0}) begin
            errors++; $display("FAIL abort_data got %h exp 000000d1000000d0", bus.o_txn_data[2*WS-1:0]);
        end
        accept();
        // The interrupting command was lost, so nothing else follows.
        tick();
        checks++;
        if (bus.o_txn_valid !== 1'b0) begin
            errors++; $display("FAIL abort_lost_cmd got valid=%b exp 0", bus.o_txn_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [SUMW-1:0] exp_s;
        drv_cmd(3'd1); drv_len(3'd2); drv_addr(32'h5555AAAA); tick();
        drv_data(32'hCAFE); tick();
        do_reset();
        checks++;
        if (bus.o_txn_valid !== 1'b0 || obs() !== '0) begin
            errors++; $display("FAIL reset_collect got valid=%b %h exp 0 0", bus.o_txn_valid, obs());
        end
        drv_cmd(3'd0); drv_len(3'd0); drv_addr(32'hAABB0000); tick();
        model_push(3'd0, 3'd0, 32'hAABB0000, 6'd0, 6'd0, 6'd0, 1'b0);
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL reset_then_txn got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        // Reset while holding drops the held transaction.
        do_reset();
        checks++;
        if (bus.o_txn_valid !== 1'b0 || bus.o_rx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_hold got valid=%b ready=%b exp 0/1", bus.o_txn_valid, bus.o_rx_ready);
        end
    endtask

    task automatic test_dup_field();
        logic [SUMW-1:0] exp_s;
        drv_cmd(3'd1); drv_len(3'd0); drv_addr(32'h11111111); drv_f2(6'h15); tick();
        drv_addr(32'h22222222); drv_data(32'h00000005); tick();
        model_push(3'd1, 3'd0, 32'h22222222, 6'd0, 6'h15, 6'd1, 1'b1);
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.o_txn_valid !== 1'b1 || obs() !== exp_s) begin
            errors++; $display("FAIL dup_addr got valid=%b %h exp 1 %h", bus.o_txn_valid, obs(), exp_s);
        end
        accept();
    endtask

    task automatic test_random();
        logic [SUMW-1:0] exp_s;
        logic [WS-1:0]   w, a;
        logic [2:0]      c, l;
        logic [5:0]      f1, f2, ew;
        logic            hf1, hf2, send_addr, dup, e;
        int              sel, dup_at;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            c = (sel < 3) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            l = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            a = $urandom;
            f1 = 6'($urandom_range(0, 63)); hf1 = 1'($urandom_range(0, 1));
            f2 = 6'($urandom_range(0, 63)); hf2 = 1'($urandom_range(0, 1));
            send_addr = (c <= 3'd1) || 1'($urandom_range(0, 1));
            ew = model_words(c, l);
            dup = send_addr && (ew != 6'd0) && ($urandom_range(0, 3) == 0);
            dup_at = (ew != 6'd0) ? $urandom_range(0, int'(ew) - 1) : 0;
            e = model_err(c, l, dup);

            drv_cmd(c); drv_len(l);
            if (send_addr) drv_addr(a);
            if (hf1) drv_f1(f1);
            if (hf2) drv_f2(f2);
            tick();
            for (int k = 0; k < int'(ew); k++) begin
                repeat ($urandom_range(0, 2)) tick();
                w = $urandom;
                exp_data_q.push_back(w);
                drv_data(w);
                if (dup && k == dup_at) begin
                    a = $urandom;
                    drv_addr(a);
                end
                tick();
            end
            model_push(c, l, send_addr ? a : '0, hf1 ? f1 : 6'd0, hf2 ? f2 : 6'd0, ew, e);

            checks++;
            if (bus.o_txn_valid !== 1'b1) begin
                errors++; $display("FAIL rand_latency txn %0d got valid=%b exp 1", t, bus.o_txn_valid);
            end
            wait_valid_quiet();
            exp_s = exp_q.pop_front();
            checks++;
            if (obs() !== exp_s) begin
                errors++; $display("FAIL rand_summary txn %0d got %h exp %h", t, obs(), exp_s);
            end
            for (int k = 0; k < int'(ew); k++) begin
                w = exp_data_q.pop_front();
                checks++;
                if (bus.o_txn_data[k*WS +: WS] !== w) begin
                    errors++; $display("FAIL rand_data txn %0d[%0d] got %h exp %h", t, k, bus.o_txn_data[k*WS +: WS], w);
                end
            end
            repeat ($urandom_range(0, 2)) tick();
            accept();
        end
    endtask

`ifdef SLAVE_RX_ASSEMBLER_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (stat_txn !== 16'd0 || stat_err !== 16'd0) begin
            errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", stat_txn, stat_err);
        end
        test_basic();
        test_excess();
        checks++;
        if (stat_txn !== 16'd2 || stat_err !== 16'd1) begin
            errors++; $display("FAIL stats_count got %0d/%0d exp 2/1", stat_txn, stat_err);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        clear_fields();
        bus.i_cmd = '0; bus.i_addr = '0; bus.i_length = '0;
        bus.i_feature1 = '0; bus.i_feature2 = '0; bus.i_data = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold_stall();
        test_excess();
        test_overflow();
        test_bad_codes();
        test_cmd_abort();
        test_reset_mid();
        test_dup_field();
        test_random();
`ifdef SLAVE_RX_ASSEMBLER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_rx_assembler.md
SLAVE_RX_ASSEMBLER -- requirements
Module: slave_rx_assembler

Interface
REQ-001 Parameter WORD_SIZE, default 32: width of one data/address word.
REQ-002 Parameter MAX_WORDS, default 32: data capacity in words (128B max / 4B).
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_cmd, i_cmd_valid  in  3,1  command field from slave RX FSM (000 rd req, 001 wr req, 010 rd resp).
REQ-006 i_addr, i_addr_valid  in  WORD_SIZE,1  address field.
REQ-007 i_length, i_length_valid  in  3,1  size code; 000=4B … 101=128B.
REQ-008 i_feature1/2, i_feature1/2_valid  in  6,1 each  extended-mode feature fields.
REQ-009 i_data, i_data_valid  in  WORD_SIZE,1  one data word per valid cycle.
REQ-010 o_rx_ready  out  1  drives slave RX FSM ready; high when able to accept fields.
REQ-011 o_txn_valid  out  1  assembled transaction available.
REQ-012 i_txn_ready  in  1  consumer accepts transaction.
REQ-013 o_txn_cmd/o_txn_length/o_txn_addr/o_txn_feature1/o_txn_feature2  out  3/3/WORD_SIZE/6/6  captured fields.
REQ-014 o_txn_data  out  MAX_WORDS*WORD_SIZE  word k at bits [k*WORD_SIZE +: WORD_SIZE].
REQ-015 o_txn_words  out  6  data words captured (0..32).
REQ-016 o_txn_err  out  1  transaction carries a protocol error.

Function
REQ-017 FSM states IDLE, COLLECT, HOLD; encoding free.
REQ-018 o_rx_ready = 1 in IDLE and COLLECT, 0 in HOLD; inputs ignored while 0.
REQ-019 IDLE: field valids without i_cmd_valid discarded; i_cmd_valid -> clear all capture regs/flags, capture cmd plus any same-cycle fields, go COLLECT (or HOLD if already complete).
REQ-020 Expected words: cmd 000 -> 0; else 1<<i_length; length 110/111 -> 0 words and err=1.
REQ-021 Complete when length captured AND word count == expected AND (addr captured if cmd is 000/001); cmd 010 needs no addr.
REQ-022 Completion evaluated including fields arriving that cycle; transition to HOLD on that edge, o_txn_valid high next cycle (latency 1 after last field).
REQ-023 Data words stored at index = word count, count increments per i_data_valid; words beyond expected, or beyond MAX_WORDS, dropped and set err.
REQ-024 Data arriving before length: stored and counted; completion rechecked once length arrives; excess -> err.
REQ-025 Repeated field valid (addr/length/feature) within one transaction: last value wins, err set.
REQ-026 Feature fields optional; uncaptured features output 0.
REQ-027 i_cmd_valid in COLLECT: current transaction forced to HOLD with err=1; new cmd is lost (ready was high, so field consumed).
REQ-028 Unknown cmd (011–111): captured, expected words 0, no addr required, err=1.
REQ-029 HOLD: outputs stable; o_txn_valid && i_txn_ready -> IDLE next cycle; no bypass to COLLECT in the same cycle.

Reset
REQ-030 rst_n low at clock edge: state IDLE; o_txn_valid 0; all o_txn_* fields, counts, err 0; o_rx_ready 1 on first cycle after reset.
REQ-031 Reset mid-COLLECT or mid-HOLD discards the transaction without emitting it.

Configuration
REQ-032 Macro SLAVE_RX_ASSEMBLER_STATS_EN defined: outputs o_stat_txn_cnt (16b, increments per accepted transaction handshake) and o_stat_err_cnt (16b, increments per handshake with err=1); both wrap, reset to 0.
REQ-033 Macro undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-034 cmd=001,len=001,addr=FFDD0000, data 000000AA,000000BB on consecutive cycles -> o_txn_valid 1 cycle after BB, words=2, data[63:0]=000000BB_000000AA, err=0.
REQ-035 cmd=000,len=010,addr=00000AAA,f1=02,f2=07 same cycle, i_txn_ready held 0 for 5 cycles -> outputs stable, o_rx_ready 0 throughout, IDLE after ready.
REQ-036 cmd=010,len=001, three data words 1234,5678,2444 -> third dropped, words=2, err=1.
REQ-037 cmd=001,len=010 then second i_cmd_valid after 2 data words -> emitted with words=2, err=1.
REQ-038 rst_n low during COLLECT after 1 data word, then cmd=000,len=000,addr=AABB0000 -> only second transaction emitted, words=0, err=0.
REQ-039 With STATS_EN: REQ-034 then REQ-036 sequences -> txn_cnt=2, err_cnt=1.
